// File: rtl/jk_pkg.sv
// Shared types and defaults for the JK bank driver: FSM states, JK command
// encodings and parameter defaults.
package jk_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_RETRY = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Encoded as {j,k} so a command can be assigned straight onto the pins.
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_cmd_t;

endpackage

// File: rtl/jk_excite.sv
// Per-bit JK excitation: chooses the command that moves one flop from q to
// target, using toggle or set/reset depending on tgl_mode.
module jk_excite
    import jk_pkg::*;
(
    input  logic q,
    input  logic target,
    input  logic tgl_mode,
    output logic j,
    output logic k
);

    jk_cmd_t cmd;

    always_comb begin
        cmd = JK_HOLD;
        if (q != target) begin
            if (tgl_mode)
                cmd = JK_TGL;
            else if (target)
                cmd = JK_SET;
            else
                cmd = JK_RST;
        end
    end

    assign {j, k} = cmd;

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a bank of JK flops to a requested state and verifies the readback.
// Define JK_DRV_RETRY_EN to re-drive up to MAX_RETRY extra times on a mismatch.
module jk_bank_driver
    import jk_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_RETRY = DEF_MAX_RETRY
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] target,
    input  logic             tgl_mode,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             done,
    output logic             err,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] target_reg;
    logic             tgl_reg;
    logic [WIDTH-1:0] j_next;
    logic [WIDTH-1:0] k_next;
    logic             match;

    // Excitation always works from the live readback, so a retry naturally
    // re-targets only the bits that are still wrong.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            jk_excite u_excite (
                .q        (q_fb[gi]),
                .target   (target_reg[gi]),
                .tgl_mode (tgl_reg),
                .j        (j_next[gi]),
                .k        (k_next[gi])
            );
        end
    endgenerate

    assign match     = (q_fb == target_reg);
    assign req_ready = (state == ST_IDLE);

`ifdef JK_DRV_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0] retry_cnt;
    logic          retry_ok;
    assign retry_ok = (retry_cnt < RW'(MAX_RETRY));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            target_reg <= '0;
            tgl_reg    <= 1'b0;
            j          <= '0;
            k          <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
`ifdef JK_DRV_RETRY_EN
            retry_cnt  <= '0;
`endif
        end else begin
            // j/k and the completion flags are pulses; default them low.
            j    <= '0;
            k    <= '0;
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        target_reg <= target;
                        tgl_reg    <= tgl_mode;
                        busy       <= 1'b1;
                        state      <= ST_DRIVE;
`ifdef JK_DRV_RETRY_EN
                        retry_cnt  <= '0;
`endif
                    end
                end
                ST_DRIVE: begin
                    j     <= j_next;
                    k     <= k_next;
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (match) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
`ifdef JK_DRV_RETRY_EN
                    end else if (retry_ok) begin
                        retry_cnt <= retry_cnt + RW'(1);
                        state     <= ST_DRIVE;
`endif
                    end else begin
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
